// File: rtl/rwa_pkg.sv
// Shared constants and state encoding for the register write arbiter.
package rwa_pkg;

   localparam int RWA_DATA_W = 8;
   localparam int RWA_ADDR_W = 3;
   localparam int NUM_REGS   = 2 ** RWA_ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rwa_state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Masked round-robin pick: lowest request at or above ptr, else lowest overall.
module rr_arbiter
   import rwa_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   logic [N-1:0] mask;
   logic [N-1:0] masked;
   logic [N-1:0] pick;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (PW'(i) >= ptr);
      end
      masked = req & mask;
      pick   = (|masked) ? masked : req;
      // isolate lowest set bit
      gnt    = pick & (~pick + 1'b1);
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) idx = PW'(i);
      end
      any = |req;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write port arbiter with clear-sweep sequencer.
// Define RWA_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module reg_write_arbiter
   import rwa_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int DATA_W = RWA_DATA_W,
   parameter int ADDR_W = RWA_ADDR_W
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic [NREQ-1:0]          REQ,
   input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
   input  logic [NREQ*DATA_W-1:0]   REQ_DATA,
   output logic [NREQ-1:0]          GNT,
   input  logic                     CLR_START,
   output logic                     CLR_BUSY,
   output logic                     CLR_DONE,
   output logic                     WRITE,
   output logic [ADDR_W-1:0]        INADDRESS,
   output logic [DATA_W-1:0]        IN
);

   localparam int PW = (NREQ > 2) ? 2 : 1;
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] SWEEP_END = CW'(2 ** ADDR_W);

   rwa_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [PW-1:0]     ptr;
   logic [NREQ-1:0]   arb_gnt;
   logic [PW-1:0]     arb_idx;
   logic              arb_any;
   logic              arb_en;
   logic              arb_win;

   logic [NREQ-1:0]   gnt_d;
   logic              write_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] in_d;
   logic              busy_d;
   logic              done_d;

   rr_arbiter #(
      .N  (NREQ),
      .PW (PW)
   ) u_rr (
      .req (REQ),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      write_d = 1'b0;
      addr_d  = INADDRESS;
      in_d    = IN;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      arb_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (CLR_START) begin
               state_d = CLEAR;
               cnt_d   = CW'(1);
               write_d = 1'b1;
               addr_d  = '0;
               in_d    = '0;
               busy_d  = 1'b1;
            end else begin
               arb_en = 1'b1;
            end
         end
         CLEAR: begin
            if (cnt_q == SWEEP_END) begin
               state_d = IDLE;
               done_d  = 1'b1;
               arb_en  = 1'b1;
            end else begin
               write_d = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               in_d    = '0;
               busy_d  = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      arb_win = arb_en & arb_any;
      // the done cycle may carry a pending grant's write
      if (arb_win) begin
         gnt_d   = arb_gnt;
         write_d = 1'b1;
         addr_d  = REQ_ADDR[32'(arb_idx)*ADDR_W +: ADDR_W];
         in_d    = REQ_DATA[32'(arb_idx)*DATA_W +: DATA_W];
      end
   end

`ifdef RWA_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [PW-1:0] ptr_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ptr_q <= '0;
      end else if (arb_win) begin
         ptr_q <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
      end
   end

   assign ptr = ptr_q;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         GNT       <= '0;
         WRITE     <= 1'b0;
         INADDRESS <= '0;
         IN        <= '0;
         CLR_BUSY  <= 1'b0;
         CLR_DONE  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         GNT       <= gnt_d;
         WRITE     <= write_d;
         INADDRESS <= addr_d;
         IN        <= in_d;
         CLR_BUSY  <= busy_d;
         CLR_DONE  <= done_d;
      end
   end

endmodule
